// File: rtl/imem_loader_pkg.sv
// Shared core definitions used by the instruction-memory boot loader.
package core;

  localparam int DATA_WIDTH         = 32;
  localparam int LOADER_DEPTH_WORDS = 1024;
  localparam logic [31:0] LOADER_MAGIC = 32'h52564C44;

  typedef enum logic [2:0] {
    MAGIC,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  // Magic bytes are sent LSB first, so byte idx is lane idx of LOADER_MAGIC.
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    return LOADER_MAGIC[8*idx +: 8];
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream, writes instruction memory byte by
// byte and releases the core reset once a checksum-valid image is in place.
module imem_loader
  import core::*;
#(
  parameter int DATA_WIDTH  = core::DATA_WIDTH,
  parameter int DATA_BYTES  = DATA_WIDTH / 8,
  parameter int DEPTH_WORDS = LOADER_DEPTH_WORDS,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic [ADDR_W-1:0]     waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_BYTES-1:0] wen_o,
  output logic                  core_rst_o,
  output logic                  done_o,
  output logic                  err_o
);

  loader_state_t state;
  logic [1:0]    idx;
  logic [31:0]   bcnt;
  logic [31:0]   n_words;
  logic [7:0]    csum;

  logic          accept;
  logic [31:0]   len_next;
  logic          last_byte;

  assign accept    = byte_valid_i && byte_ready_o;
  assign len_next  = {byte_i, n_words[31:8]};
  assign last_byte = (bcnt + 32'd1) == {n_words[29:0], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= MAGIC;
      idx          <= '0;
      bcnt         <= '0;
      n_words      <= '0;
      csum         <= '0;
      byte_ready_o <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      wen_o        <= '0;
      core_rst_o   <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      wen_o        <= '0;
      byte_ready_o <= (state != DONE) && (state != ERR);
      if (accept) begin
        unique case (state)
          MAGIC: begin
            // On mismatch the same byte may itself start a new magic sequence.
            if (byte_i == magic_byte(idx)) begin
              idx <= idx + 2'd1;
              if (idx == 2'd3) state <= LEN;
            end else begin
              idx <= (byte_i == magic_byte(2'd0)) ? 2'd1 : 2'd0;
            end
          end
          LEN: begin
            n_words <= len_next;
            idx     <= idx + 2'd1;
            if (idx == 2'd3) begin
              if (len_next > 32'(DEPTH_WORDS)) begin
                state        <= ERR;
                err_o        <= 1'b1;
                byte_ready_o <= 1'b0;
              end else if (len_next == '0) begin
                state <= CSUM;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            waddr_o <= bcnt[ADDR_W+1:2];
            wdata_o <= {DATA_BYTES{byte_i}};
            wen_o   <= DATA_BYTES'(1) << bcnt[1:0];
            csum    <= csum ^ byte_i;
            bcnt    <= bcnt + 32'd1;
            if (last_byte) state <= CSUM;
          end
          CSUM: begin
            byte_ready_o <= 1'b0;
            if (byte_i == csum) begin
              state      <= DONE;
              done_o     <= 1'b1;
              core_rst_o <= 1'b1;
            end else begin
              state <= ERR;
              err_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
